// File: rtl/conv2d_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_stream_if
// Brief    : Coefficient, pixel and result handshakes of the conv2d engine.
// Revision : 1.0
// ============================================================================
interface conv2d_stream_if #(
    parameter int DW = 16
);
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          frame_done;

    modport slave (
        input  w_valid, w_data, in_valid, in_data, out_ready,
        output w_ready, in_ready, out_valid, out_data, frame_done
    );

    modport master (
        output w_valid, w_data, in_valid, in_data, out_ready,
        input  w_ready, in_ready, out_valid, out_data, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_stream_engine
// Brief    : Streaming KxK 2D convolution with line buffers, registered MAC
//            and saturated fixed-point output.
// Revision : 1.0
// ============================================================================
module conv2d_stream_engine #(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 2,
    parameter int STRIDE = 1,
    parameter int DW     = 16,
    parameter int FRAC   = 0
) (
    input  logic           clk_en,
    input  logic           rst_n,
    conv2d_stream_if.slave bus
);
    localparam int C_NW = K * K;
    localparam int C_IW = $clog2(C_NW + 1);
    localparam int C_AW = 2 * DW + $clog2(C_NW) + 1;
    localparam int C_CW = $clog2(IMG_W + 1);
    localparam int C_RW = $clog2(IMG_H + 1);
    localparam int C_PW = $clog2(STRIDE + 1);
    localparam int C_LB = (K - 1) * IMG_W;

    localparam logic [C_IW-1:0] C_IDX_BIAS = C_IW'(C_NW);
    localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(IMG_W - 1);
    localparam logic [C_CW-1:0] C_COL_WIN  = C_CW'(K - 1);
    localparam logic [C_RW-1:0] C_ROW_LAST = C_RW'(IMG_H - 1);
    localparam logic [C_RW-1:0] C_ROW_WIN  = C_RW'(K - 1);
    localparam logic [C_PW-1:0] C_PH_LAST  = C_PW'(STRIDE - 1);

    localparam logic signed [DW-1:0]   C_RES_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   C_RES_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [C_AW-1:0] C_ACC_MAX = C_AW'(C_RES_MAX);
    localparam logic signed [C_AW-1:0] C_ACC_MIN = C_AW'(C_RES_MIN);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DW-1:0]   r_wgt [C_NW];
    logic signed [DW-1:0]   r_bias;
    logic [C_IW-1:0]        r_widx;
    logic [C_IW-1:0]        w_widx_cur;

    logic [C_CW-1:0]        r_col;
    logic [C_RW-1:0]        r_row;
    logic [C_PW-1:0]        r_col_ph;
    logic [C_PW-1:0]        r_row_ph;

    logic signed [DW-1:0]   r_win [K][K];
    logic signed [DW-1:0]   w_tap [K];
    logic                   r_win_v;
    logic                   r_mac_v;
    logic signed [C_AW-1:0] r_acc;
    logic                   r_out_valid;
    logic [DW-1:0]          r_out_data;

    logic                   w_pipe_empty;
    logic                   w_frame_idle;
    logic                   w_wr_ready;
    logic                   w_wr_fire;
    logic                   w_in_ready;
    logic                   w_px_fire;
    logic                   w_last_px;
    logic                   w_win_ok;
    logic                   w_out_adv;
    logic                   w_mac_adv;
    logic                   w_drain_done;
    logic signed [2*DW-1:0] w_prod;
    logic signed [C_AW-1:0] w_sum;
    logic signed [C_AW-1:0] w_shr;
    logic [DW-1:0]          w_sat;

    // ------------------------------------------------------------------ control
    assign w_pipe_empty = !r_win_v && !r_mac_v && !r_out_valid;
    assign w_frame_idle = (r_row == '0) && (r_col == '0);
    assign w_wr_ready   = (r_state == ST_EMPTY) || (r_state == ST_LOAD) ||
                          ((r_state == ST_RUN) && w_frame_idle && w_pipe_empty);
    assign w_wr_fire    = bus.w_valid && w_wr_ready;
    assign w_widx_cur   = (r_state == ST_LOAD) ? r_widx : '0;

    assign w_out_adv    = !r_out_valid || bus.out_ready;
    assign w_mac_adv    = !r_mac_v || w_out_adv;
    // A coefficient reload between frames wins over the first pixel of a frame.
    assign w_in_ready   = (r_state == ST_RUN) && !(r_mac_v && r_out_valid && !bus.out_ready)
                          && !w_wr_fire;
    assign w_px_fire    = bus.in_valid && w_in_ready;
    assign w_last_px    = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);
    assign w_win_ok     = (r_row >= C_ROW_WIN) && (r_col >= C_COL_WIN) &&
                          (r_row_ph == '0) && (r_col_ph == '0);
    assign w_drain_done = !r_win_v && !r_mac_v && w_out_adv;

    assign bus.w_ready    = w_wr_ready;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.frame_done = (r_state == ST_DRAIN) && w_drain_done;

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_wr_fire) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_wr_fire && (r_widx == C_IDX_BIAS)) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_wr_fire) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_px_fire && w_last_px) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (w_drain_done) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------ coefficients
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_widx <= '0;
            r_bias <= '0;
            for (int i = 0; i < C_NW; i++) r_wgt[i] <= '0;
        end else if (w_wr_fire) begin
            if (w_widx_cur == C_IDX_BIAS) begin
                r_bias <= bus.w_data;
                r_widx <= '0;
            end else begin
                r_widx <= w_widx_cur + 1'b1;
            end
            for (int i = 0; i < C_NW; i++) begin
                if (w_widx_cur == C_IW'(i)) r_wgt[i] <= bus.w_data;
            end
        end
    end

    // ------------------------------------------- raster position, stride phase
    // Phases stay 0 until the position reaches K-1, then count modulo STRIDE.
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (w_px_fire) begin
            if (r_col == C_COL_LAST) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (r_row == C_ROW_LAST) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row    <= r_row + 1'b1;
                    r_row_ph <= (r_row < C_ROW_WIN || r_row_ph == C_PH_LAST) ? '0
                                                                             : r_row_ph + 1'b1;
                end
            end else begin
                r_col    <= r_col + 1'b1;
                r_col_ph <= (r_col < C_COL_WIN || r_col_ph == C_PH_LAST) ? '0
                                                                         : r_col_ph + 1'b1;
            end
        end
    end

    // ------------------------------------------------ line buffers and window
    assign w_tap[K-1] = bus.in_data;

    generate
        if (K > 1) begin : g_lb
            logic signed [DW-1:0] r_lb [C_LB];

            always_ff @(posedge clk_en or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < C_LB; i++) r_lb[i] <= '0;
                end else if (w_px_fire) begin
                    r_lb[0] <= bus.in_data;
                    for (int i = 1; i < C_LB; i++) r_lb[i] <= r_lb[i-1];
                end
            end

            // Window row i holds image row (current - (K-1-i)).
            for (genvar gi = 0; gi < K - 1; gi++) begin : g_tap
                assign w_tap[gi] = r_lb[(K-1-gi)*IMG_W - 1];
            end
        end
    endgenerate

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) r_win[i][j] <= '0;
        end else if (w_px_fire) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) r_win[i][j] <= r_win[i][j+1];
                r_win[i][K-1] <= w_tap[i];
            end
        end
    end

    // ------------------------------------------------------------ arithmetic
    always_comb begin
        w_prod = '0;
        w_sum  = C_AW'(r_bias) <<< FRAC;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_prod = r_win[i][j] * r_wgt[i*K + j];
                w_sum  = w_sum + C_AW'(w_prod);
            end
        end
    end

    assign w_shr = r_acc >>> FRAC;
    assign w_sat = (w_shr > C_ACC_MAX) ? C_RES_MAX :
                   (w_shr < C_ACC_MIN) ? C_RES_MIN : w_shr[DW-1:0];

    // --------------------------------------------- window -> MAC -> output
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_win_v     <= 1'b0;
            r_mac_v     <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // A new pixel can only arrive when the MAC stage is free to take the window.
            if (w_px_fire) begin
                r_win_v <= w_win_ok;
            end else if (w_mac_adv) begin
                r_win_v <= 1'b0;
            end
            if (w_mac_adv) begin
                r_mac_v <= r_win_v;
                if (r_win_v) r_acc <= w_sum;
            end
            if (w_out_adv) begin
                r_out_valid <= r_mac_v;
                if (r_mac_v) r_out_data <= w_sat;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2d_stream_engine
// Brief    : Directed, table-driven bench for conv2d_stream_engine.
// Revision : 1.0
// ============================================================================
module tb_conv2d_stream_engine;
    localparam int DW = 16;

    logic          clk_en = 1'b0;
    logic          rst_n  = 1'b0;
    logic          w_valid = 1'b0;
    logic [DW-1:0] w_data  = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          out_ready = 1'b1;
    int            sel = 0;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    always #5 clk_en = ~clk_en;

    conv2d_stream_if #(.DW(DW)) bus_a ();
    conv2d_stream_if #(.DW(DW)) bus_b ();
    conv2d_stream_if #(.DW(DW)) bus_c ();

    assign bus_a.w_valid = w_valid;   assign bus_a.w_data = w_data;
    assign bus_a.in_valid = in_valid; assign bus_a.in_data = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.w_valid = w_valid;   assign bus_b.w_data = w_data;
    assign bus_b.in_valid = in_valid; assign bus_b.in_data = in_data;
    assign bus_b.out_ready = out_ready;
    assign bus_c.w_valid = w_valid;   assign bus_c.w_data = w_data;
    assign bus_c.in_valid = in_valid; assign bus_c.in_data = in_data;
    assign bus_c.out_ready = out_ready;

    conv2d_stream_engine #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(1), .DW(DW), .FRAC(0))
        dut_a (.clk_en(clk_en), .rst_n(rst_n), .bus(bus_a.slave));
    conv2d_stream_engine #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2), .DW(DW), .FRAC(0))
        dut_b (.clk_en(clk_en), .rst_n(rst_n), .bus(bus_b.slave));
    conv2d_stream_engine #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(1), .DW(DW), .FRAC(8))
        dut_c (.clk_en(clk_en), .rst_n(rst_n), .bus(bus_c.slave));

    logic          s_w_ready, s_in_ready, s_out_valid, s_frame_done;
    logic [DW-1:0] s_out_data;

    always_comb begin
        case (sel)
            1: begin
                s_w_ready = bus_b.w_ready; s_in_ready = bus_b.in_ready;
                s_out_valid = bus_b.out_valid; s_out_data = bus_b.out_data;
                s_frame_done = bus_b.frame_done;
            end
            2: begin
                s_w_ready = bus_c.w_ready; s_in_ready = bus_c.in_ready;
                s_out_valid = bus_c.out_valid; s_out_data = bus_c.out_data;
                s_frame_done = bus_c.frame_done;
            end
            default: begin
                s_w_ready = bus_a.w_ready; s_in_ready = bus_a.in_ready;
                s_out_valid = bus_a.out_valid; s_out_data = bus_a.out_data;
                s_frame_done = bus_a.frame_done;
            end
        endcase
    end

    // Input must be held off whenever both result stages hold data that cannot leave.
    always @(negedge clk_en) begin
        if (rst_n && bus_a.in_ready && dut_a.r_mac_v && bus_a.out_valid && !out_ready)
            viol++;
    end

    typedef struct packed {
        logic [1:0]        sel;
        logic              reload;
        logic              stress;
        logic              pconst;
        logic [15:0]       pval;
        logic [3:0][15:0]  w;
        logic [15:0]       bias;
        logic [3:0]        n;
        logic [8:0][15:0]  exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_en);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; w_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_word(input bit is_w, input logic [15:0] d);
        bit done = 1'b0;
        int n = 0;
        if (is_w) begin w_valid = 1'b1; w_data = d; end
        else      begin in_valid = 1'b1; in_data = d; end
        while (!done && n < 500) begin
            @(negedge clk_en);
            done = is_w ? s_w_ready : s_in_ready;
            tick();
            n++;
        end
        w_valid = 1'b0;
        in_valid = 1'b0;
        check(is_w ? "w_accept" : "px_accept", 32'(done), 32'd1);
    endtask

    task automatic load_weights(input vec_t v);
        for (int i = 0; i < 4; i++) send_word(1'b1, v.w[i]);
        send_word(1'b1, v.bias);
    endtask

    task automatic run_frame(input vec_t v);
        int got = 0, fd = 0, cyc = 0, extra = 0;
        fork
            begin
                for (int p = 0; p < 16; p++) begin
                    if (v.stress && $urandom_range(0, 2) == 0) tick();
                    send_word(1'b0, v.pconst ? v.pval : 16'(p + 1));
                end
            end
            begin
                while (got < int'(v.n) && cyc < 3000) begin
                    out_ready = v.stress ? ($urandom_range(0, 9) < 3) : 1'b1;
                    @(negedge clk_en);
                    if (s_frame_done) fd++;
                    if (s_out_valid && out_ready) begin
                        check($sformatf("result[%0d]", got), 32'(s_out_data), 32'(v.exp[got]));
                        got++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) begin
            @(negedge clk_en);
            if (s_frame_done) fd++;
            if (s_out_valid) extra++;
            tick();
        end
        check("result_count", 32'(got), 32'(v.n));
        check("extra_results", 32'(extra), 32'd0);
        check("frame_done_count", 32'(fd), 32'd1);
    endtask

    initial begin
        int prev_sel;

        vecs[0] = '0;
        vecs[0].sel = 2'd0; vecs[0].reload = 1'b1; vecs[0].w = {4{16'd1}}; vecs[0].n = 4'd9;
        vecs[0].exp = {16'd54, 16'd50, 16'd46, 16'd38, 16'd34, 16'd30, 16'd22, 16'd18, 16'd14};
        vecs[1] = vecs[0]; vecs[1].reload = 1'b0; vecs[1].stress = 1'b1;
        vecs[2] = vecs[0]; vecs[2].bias = 16'd5; vecs[2].exp = '0;
        vecs[2].w = {16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
        vecs[3] = '0;
        vecs[3].sel = 2'd1; vecs[3].reload = 1'b1; vecs[3].w = {4{16'd1}}; vecs[3].n = 4'd4;
        vecs[3].exp = {80'd0, 16'd54, 16'd46, 16'd22, 16'd14};
        vecs[4] = vecs[3]; vecs[4].reload = 1'b0;
        vecs[5] = '0;
        vecs[5].sel = 2'd2; vecs[5].reload = 1'b1; vecs[5].w = {4{16'h7FFF}}; vecs[5].n = 4'd9;
        vecs[5].pconst = 1'b1; vecs[5].pval = 16'h7FFF; vecs[5].exp = {9{16'h7FFF}};
        vecs[6] = vecs[5]; vecs[6].pval = 16'h8000; vecs[6].exp = {9{16'h8000}};

        repeat (2) tick();
        @(negedge clk_en);
        check("rst_w_ready",    32'(s_w_ready),    32'd1);
        check("rst_in_ready",   32'(s_in_ready),   32'd0);
        check("rst_out_valid",  32'(s_out_valid),  32'd0);
        check("rst_out_data",   32'(s_out_data),   32'd0);
        check("rst_frame_done", 32'(s_frame_done), 32'd0);
        rst_n = 1'b1;
        tick();

        prev_sel = -1;
        for (int i = 0; i < 7; i++) begin
            sel = int'(vecs[i].sel);
            if (sel != prev_sel) do_reset();
            prev_sel = sel;
            if (vecs[i].reload) begin
                load_weights(vecs[i]);
                @(negedge clk_en);
                check("in_ready_after_load", 32'(s_in_ready), 32'd1);
                check("w_ready_between_frames", 32'(s_w_ready), 32'd1);
                tick();
            end
            viol = 0;
            run_frame(vecs[i]);
            if (vecs[i].stress) check("in_ready_while_full", 32'(viol), 32'd0);
        end

        // Reset in the middle of a frame, then reload and stream a fresh frame.
        sel = 0;
        do_reset();
        load_weights(vecs[0]);
        for (int p = 0; p < 7; p++) send_word(1'b0, 16'(p + 1));
        @(negedge clk_en);
        check("w_ready_midframe", 32'(s_w_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid",  32'(s_out_valid),  32'd0);
        check("midrst_out_data",   32'(s_out_data),   32'd0);
        check("midrst_in_ready",   32'(s_in_ready),   32'd0);
        check("midrst_w_ready",    32'(s_w_ready),    32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk_en);
        check("no_weights_in_ready", 32'(s_in_ready), 32'd0);
        tick();
        load_weights(vecs[0]);
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
